// File: rtl/iopmp_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iopmp_mem_pkg : shared types and byte-merge helper for entry mem ctrl |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package iopmp_mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } port_state_e;

    localparam int unsigned MAX_DATA_WIDTH = 1024;

    // Mask is the byte enables expanded to one bit per data bit.
    function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_DATA_WIDTH-1:0] bit_mask
    );
        return (new_word & bit_mask) | (old_word & ~bit_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iopmp_mem_port_eng.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iopmp_mem_port_eng : per-port request FSM, RMW merge and rsp register |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module iopmp_mem_port_eng
    import iopmp_mem_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned AddrWidth = 10,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    input  logic [BeWidth-1:0]   req_be_i,
    input  logic                 block_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 rmw_busy_o,
    output logic [AddrWidth-1:0] lock_addr_o
);

    port_state_e          state_q, state_d;
    logic [AddrWidth-1:0] lock_addr_q, lock_addr_d;
    logic [DataWidth-1:0] merged_q, merged_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DataWidth-1:0] be_mask;
    logic                 fire;

    for (genvar gi = 0; gi < DataWidth; gi++) begin : g_mask
        assign be_mask[gi] = req_be_i[gi / ByteWidth];
    end

    // Gating with rst_ni keeps every memory-side output low while reset is held.
    assign req_ready_o = rst_ni && (state_q == IDLE) && (!rsp_valid_q || rsp_ready_i) && !block_i;
    assign fire        = req_valid_i && req_ready_o;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rmw_busy_o  = (state_q == RMW_WR);
    assign lock_addr_o = lock_addr_q;

    always_comb begin
        state_d     = state_q;
        lock_addr_d = lock_addr_q;
        merged_d    = merged_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;
        rsp_rdata_d = rsp_rdata_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (!req_we_i) begin
                        mem_req_o   = 1'b1;
                        mem_addr_o  = req_addr_i;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = mem_rdata_i;
                    end else if (req_be_i == '0) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (&req_be_i) begin
                        mem_req_o   = 1'b1;
                        mem_we_o    = 1'b1;
                        mem_addr_o  = req_addr_i;
                        mem_wdata_o = req_wdata_i;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        // Partial write: read now, write the merged word next cycle.
                        mem_req_o   = 1'b1;
                        mem_addr_o  = req_addr_i;
                        lock_addr_d = req_addr_i;
                        merged_d    = DataWidth'(merge_bytes(MAX_DATA_WIDTH'(mem_rdata_i),
                                                             MAX_DATA_WIDTH'(req_wdata_i),
                                                             MAX_DATA_WIDTH'(be_mask)));
                        state_d     = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = lock_addr_q;
                mem_wdata_o = merged_q;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lock_addr_q <= '0;
            merged_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_addr_q <= lock_addr_d;
            merged_q    <= merged_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iopmp_entry_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iopmp_entry_mem_ctrl : two-port request controller for entry memory  |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module iopmp_entry_mem_ctrl
    import iopmp_mem_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0]                req_valid_i,
    output logic [1:0]                req_ready_o,
    input  logic [1:0]                req_we_i,
    input  logic [1:0][AddrWidth-1:0] req_addr_i,
    input  logic [1:0][DataWidth-1:0] req_wdata_i,
    input  logic [1:0][BeWidth-1:0]   req_be_i,
    output logic [1:0]                rsp_valid_o,
    input  logic [1:0]                rsp_ready_i,
    output logic [1:0][DataWidth-1:0] rsp_rdata_o,
    output logic [1:0]                mem_req_o,
    output logic [1:0]                mem_we_o,
    output logic [1:0][AddrWidth-1:0] mem_addr_o,
    output logic [1:0][DataWidth-1:0] mem_wdata_o,
    input  logic [1:0][DataWidth-1:0] mem_rdata_i
);

    logic [1:0]                rmw_busy;
    logic [1:0][AddrWidth-1:0] lock_addr;
    logic [1:0]                block;

    // Port 0 wins simultaneous same-address writes; a port in RMW_WR locks its address.
    assign block[0] = req_we_i[0] && rmw_busy[1] && (req_addr_i[0] == lock_addr[1]);
    assign block[1] = (req_valid_i[0] && req_we_i[0] && req_we_i[1] &&
                       (req_addr_i[0] == req_addr_i[1])) ||
                      (req_we_i[1] && rmw_busy[0] && (req_addr_i[1] == lock_addr[0]));

    for (genvar gp = 0; gp < 2; gp++) begin : g_port
        iopmp_mem_port_eng #(
            .DataWidth (DataWidth),
            .ByteWidth (ByteWidth),
            .AddrWidth (AddrWidth),
            .BeWidth   (BeWidth)
        ) u_eng (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .req_valid_i (req_valid_i[gp]),
            .req_ready_o (req_ready_o[gp]),
            .req_we_i    (req_we_i[gp]),
            .req_addr_i  (req_addr_i[gp]),
            .req_wdata_i (req_wdata_i[gp]),
            .req_be_i    (req_be_i[gp]),
            .block_i     (block[gp]),
            .rsp_valid_o (rsp_valid_o[gp]),
            .rsp_ready_i (rsp_ready_i[gp]),
            .rsp_rdata_o (rsp_rdata_o[gp]),
            .mem_req_o   (mem_req_o[gp]),
            .mem_we_o    (mem_we_o[gp]),
            .mem_addr_o  (mem_addr_o[gp]),
            .mem_wdata_o (mem_wdata_o[gp]),
            .mem_rdata_i (mem_rdata_i[gp]),
            .rmw_busy_o  (rmw_busy[gp]),
            .lock_addr_o (lock_addr[gp])
        );
    end

endmodule
`default_nettype wire
